// File: rtl/data_memory_stage_pkg.sv
// Shared definitions for the MEM-stage data memory: access size codes,
// load/store codes, FSM encoding and small decode helpers.
package data_memory_stage_pkg;

  typedef enum logic [1:0] {
    DM_BYTE = 2'b00,
    DM_HALF = 2'b01,
    DM_WORD = 2'b10,
    DM_RSVD = 2'b11   // decoded as a word access
  } dm_size_e;

  localparam logic DM_LOAD  = 1'b0;
  localparam logic DM_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dm_state_e;

  localparam int CNT_W = 4;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] dm_nbytes(dm_size_e s);
    case (s)
      DM_BYTE: dm_nbytes = 3'd1;
      DM_HALF: dm_nbytes = 3'd2;
      default: dm_nbytes = 3'd4;
    endcase
  endfunction

  // Natural-alignment test on the low address bits.
  function automatic logic dm_misaligned(dm_size_e s, logic [1:0] lo);
    case (s)
      DM_BYTE: dm_misaligned = 1'b0;
      DM_HALF: dm_misaligned = lo[0];
      default: dm_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_memory_stage_if.sv
// EX/MEM -> data memory request bus and the load/stall response.
// master = pipeline side, slave = memory stage.
interface data_memory_stage_if #(
  parameter int ADDR_W = 9
);
  logic              MEM_load_instr;
  logic              MEM_Read_Write;
  logic              MEM_SE_dm;
  logic [1:0]        MEM_size_dm;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rdata_valid;
  logic              mem_stall;
  logic              misalign_fault;

  modport master (
    output MEM_load_instr, MEM_Read_Write, MEM_SE_dm, MEM_size_dm, addr, wdata,
    input  rdata, rdata_valid, mem_stall, misalign_fault
  );

  modport slave (
    input  MEM_load_instr, MEM_Read_Write, MEM_SE_dm, MEM_size_dm, addr, wdata,
    output rdata, rdata_valid, mem_stall, misalign_fault
  );
endinterface

// File: rtl/data_memory_stage_dm_load_extend.sv
// Aligns four big-endian fetched bytes (fetched[0] = M[a]) into a 32-bit
// load result, sign- or zero-extending byte and halfword loads.
module dm_load_extend
  import data_memory_stage_pkg::*;
(
  input  logic [3:0][7:0] fetched,
  input  dm_size_e        size,
  input  logic            se,
  output logic [31:0]     result
);

  // Size select and extension; word (and reserved) ignore se.
  always_comb begin
    result = {fetched[0], fetched[1], fetched[2], fetched[3]};
    case (size)
      DM_BYTE: result = se ? {{24{fetched[0][7]}}, fetched[0]} : {24'b0, fetched[0]};
      DM_HALF: result = se ? {{16{fetched[0][7]}}, fetched[0], fetched[1]}
                           : {16'b0, fetched[0], fetched[1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_stage.sv
// MEM-stage big-endian byte-addressed data memory with configurable wait
// states. mem_stall holds the upstream pipeline so the request fields stay
// stable until the access edge. Byte addresses a+k wrap at the array size
// (DEPTH is expected to equal 2**ADDR_W).
// Optional feature: define DM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with a one-cycle misalign_fault pulse instead of executing them.
module data_memory_stage
  import data_memory_stage_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic                Clk,
  input  logic                R,
  data_memory_stage_if.slave  bus
);

  dm_state_e         state, nstate;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              access, stall;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] a_k [4];
  logic [3:0][7:0]   fetched;
  logic [3:0][7:0]   wbytes;
  logic [2:0]        nb;
  logic [31:0]       ld_data;
  logic              is_store, mis;
  dm_size_e          size;

  logic [31:0]       rdata_q;
  logic              rdata_valid_q, fault_q;

  // FSM state and wait counter; reset aborts any in-flight access.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, stall and the one-cycle access strobe.
  always_comb begin
    nstate  = state;
    cnt_nxt = cnt;
    stall   = 1'b0;
    access  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.MEM_load_instr) begin
          if (WAIT_STATES == 0) begin
            access = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_nxt = CNT_W'(WAIT_STATES - 1);
            nstate  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          access = 1'b1;
          nstate = ST_DONE;
        end
      end
      // Pipeline advances this cycle; a request seen here is the next one
      // and is picked up back in IDLE.
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  assign size     = dm_size_e'(bus.MEM_size_dm);
  assign is_store = (bus.MEM_Read_Write == DM_STORE);
  assign nb       = dm_nbytes(size);

`ifdef DM_ALIGN_CHECK_EN
  assign mis = dm_misaligned(size, bus.addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Wrapped byte addresses, fetched bytes and big-endian store byte lanes.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a_k[k]     = bus.addr + ADDR_W'(k);
      fetched[k] = mem[a_k[k]];
    end
    wbytes = {bus.wdata[7:0], bus.wdata[15:8], bus.wdata[23:16], bus.wdata[31:24]};
    case (size)
      DM_BYTE: wbytes[0] = bus.wdata[7:0];
      DM_HALF: begin
        wbytes[0] = bus.wdata[15:8];
        wbytes[1] = bus.wdata[7:0];
      end
      default: ;
    endcase
  end

  dm_load_extend u_ext (
    .fetched (fetched),
    .size    (size),
    .se      (bus.MEM_SE_dm),
    .result  (ld_data)
  );

  // Access edge: commit store bytes or capture load data; array is not reset.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      if (access) begin
        if (mis) begin
          fault_q <= 1'b1;
        end else if (is_store) begin
          for (int k = 0; k < 4; k++)
            if (3'(k) < nb) mem[a_k[k]] <= wbytes[k];
        end else begin
          rdata_q       <= ld_data;
          rdata_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.rdata          = rdata_q;
  assign bus.rdata_valid    = rdata_valid_q;
  assign bus.misalign_fault = fault_q;
  assign bus.mem_stall      = stall;

endmodule

// File: tb/tb_data_memory_stage.sv
// Scoreboard bench: two instances (0 and 3 wait states). Stimulus pushes the
// expected response of each load (or misalign fault) into a per-instance
// queue; monitors pop and compare whenever rdata_valid/misalign_fault fire.
module tb_data_memory_stage;
  import data_memory_stage_pkg::*;

  logic Clk = 1'b0;
  logic R0, R3;
  always #5 Clk = ~Clk;

  data_memory_stage_if #(.ADDR_W(9)) dif0 ();
  data_memory_stage_if #(.ADDR_W(9)) dif3 ();

  data_memory_stage #(.ADDR_W(9), .DEPTH(512), .WAIT_STATES(0)) u_ws0 (
    .Clk(Clk), .R(R0), .bus(dif0.slave));
  data_memory_stage #(.ADDR_W(9), .DEPTH(512), .WAIT_STATES(3)) u_ws3 (
    .Clk(Clk), .R(R3), .bus(dif3.slave));

  typedef struct {
    logic        fault;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q3[$];
  int          total = 0;
  int          bad   = 0;
  logic        stall0_seen = 1'b0;
  logic [31:0] last0 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic have, input exp_t e,
                          input logic v, input logic f, input logic [31:0] d);
    if (!have) begin
      total++;
      bad++;
      $display("FAIL %s_unexpected: got valid=%b fault=%b want no response", tag, v, f);
    end else begin
      chk({tag, "_fault"}, {31'b0, f}, {31'b0, e.fault});
      chk({tag, "_valid"}, {31'b0, v}, {31'b0, ~e.fault});
      chk({tag, "_rdata"}, d, e.data);
    end
  endtask

  // Monitors
  initial forever begin
    exp_t e;
    logic have;
    @(negedge Clk);
    if (dif0.mem_stall) stall0_seen = 1'b1;
    if (dif0.rdata_valid || dif0.misalign_fault) begin
      have = (q0.size() != 0);
      e = '{1'b0, 32'h0};
      if (have) e = q0.pop_front();
      chk_resp("ws0", have, e, dif0.rdata_valid, dif0.misalign_fault, dif0.rdata);
    end
  end

  initial forever begin
    exp_t e;
    logic have;
    @(negedge Clk);
    if (dif3.rdata_valid || dif3.misalign_fault) begin
      have = (q3.size() != 0);
      e = '{1'b0, 32'h0};
      if (have) e = q3.pop_front();
      chk_resp("ws3", have, e, dif3.rdata_valid, dif3.misalign_fault, dif3.rdata);
    end
  end

  task automatic idle0();
    dif0.MEM_load_instr = 1'b0;
    dif0.MEM_Read_Write = 1'bx;
    dif0.MEM_SE_dm      = 1'bx;
    dif0.MEM_size_dm    = 2'bxx;
    dif0.addr           = 'x;
    dif0.wdata          = 'x;
  endtask

  task automatic idle3();
    dif3.MEM_load_instr = 1'b0;
    dif3.MEM_Read_Write = 1'bx;
    dif3.MEM_SE_dm      = 1'bx;
    dif3.MEM_size_dm    = 2'bxx;
    dif3.addr           = 'x;
    dif3.wdata          = 'x;
  endtask

  // Single-cycle op on the 0-wait instance. flt: expect a misalign fault
  // (exp is then the unchanged rdata).
  task automatic op0(input logic rw, input logic se, input logic [1:0] sz,
                     input logic [8:0] a, input logic [31:0] wd,
                     input logic flt, input logic [31:0] exp);
    @(negedge Clk);
    dif0.MEM_load_instr = 1'b1;
    dif0.MEM_Read_Write = rw;
    dif0.MEM_SE_dm      = se;
    dif0.MEM_size_dm    = sz;
    dif0.addr           = a;
    dif0.wdata          = wd;
    if (flt || rw == DM_LOAD) q0.push_back('{flt, exp});
    if (!flt && rw == DM_LOAD) last0 = exp;
    @(negedge Clk);
    idle0();
  endtask

  // Op on the 3-wait instance: stall in the request cycle, then exactly
  // three WAIT cycles, then DONE with rdata_valid for loads.
  task automatic op3(input logic rw, input logic se, input logic [1:0] sz,
                     input logic [8:0] a, input logic [31:0] wd, input logic [31:0] exp);
    int n;
    @(negedge Clk);
    dif3.MEM_load_instr = 1'b1;
    dif3.MEM_Read_Write = rw;
    dif3.MEM_SE_dm      = se;
    dif3.MEM_size_dm    = sz;
    dif3.addr           = a;
    dif3.wdata          = wd;
    if (rw == DM_LOAD) q3.push_back('{1'b0, exp});
    #1 chk("ws3_req_stall", {31'b0, dif3.mem_stall}, 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (!dif3.mem_stall) break;
      n++;
    end
    chk("ws3_wait_cycles", n, 32'd3);
    chk("ws3_done_valid", {31'b0, dif3.rdata_valid}, {31'b0, rw == DM_LOAD});
    idle3();
  endtask

  initial begin
    R0 = 1'b0;
    R3 = 1'b0;
    idle0();
    idle3();
    repeat (2) @(negedge Clk);
    chk("rst_rdata0",  dif0.rdata, 32'h0);
    chk("rst_valid0",  {31'b0, dif0.rdata_valid}, 32'h0);
    chk("rst_stall0",  {31'b0, dif0.mem_stall}, 32'h0);
    chk("rst_fault0",  {31'b0, dif0.misalign_fault}, 32'h0);
    chk("rst_rdata3",  dif3.rdata, 32'h0);
    chk("rst_stall3",  {31'b0, dif3.mem_stall}, 32'h0);
    R0 = 1'b1;
    R3 = 1'b1;

    // Word store/load and extension variants
    op0(DM_STORE, 0, DM_WORD, 9'h010, 32'hDEADBEEF, 0, 0);
    op0(DM_LOAD,  0, DM_WORD, 9'h010, 0, 0, 32'hDEADBEEF);
    op0(DM_LOAD,  1, DM_BYTE, 9'h010, 0, 0, 32'hFFFFFFDE);
    op0(DM_LOAD,  0, DM_BYTE, 9'h010, 0, 0, 32'h000000DE);
    op0(DM_LOAD,  1, DM_HALF, 9'h012, 0, 0, 32'hFFFFBEEF);
    op0(DM_LOAD,  0, DM_HALF, 9'h012, 0, 0, 32'h0000BEEF);
    op0(DM_LOAD,  1, DM_BYTE, 9'h011, 0, 0, 32'hFFFFFFAD);
    op0(DM_LOAD,  1, DM_HALF, 9'h010, 0, 0, 32'hFFFFDEAD);
    op0(DM_LOAD,  1, DM_WORD, 9'h010, 0, 0, 32'hDEADBEEF);
    op0(DM_LOAD,  0, DM_RSVD, 9'h010, 0, 0, 32'hDEADBEEF);
    op0(DM_LOAD,  0, DM_BYTE, 9'h013, 0, 0, 32'h000000EF);
    op0(DM_LOAD,  1, DM_BYTE, 9'h012, 0, 0, 32'hFFFFFFBE);

`ifdef DM_ALIGN_CHECK_EN
    op0(DM_LOAD,  0, DM_HALF, 9'h011, 0, 1, 32'hFFFFFFBE);
    op0(DM_STORE, 0, DM_HALF, 9'h013, 32'h00009999, 1, 32'hFFFFFFBE);
    op0(DM_STORE, 0, DM_WORD, 9'h012, 32'h11111111, 1, 32'hFFFFFFBE);
    op0(DM_LOAD,  0, DM_WORD, 9'h010, 0, 0, 32'hDEADBEEF);
`else
    op0(DM_LOAD,  0, DM_HALF, 9'h011, 0, 0, 32'h0000ADBE);
    op0(DM_STORE, 0, DM_WORD, 9'h1FF, 32'hA1B2C3D4, 0, 0);
    op0(DM_LOAD,  0, DM_BYTE, 9'h1FF, 0, 0, 32'h000000A1);
    op0(DM_LOAD,  0, DM_BYTE, 9'h000, 0, 0, 32'h000000B2);
    op0(DM_LOAD,  0, DM_BYTE, 9'h001, 0, 0, 32'h000000C3);
    op0(DM_LOAD,  0, DM_BYTE, 9'h002, 0, 0, 32'h000000D4);
    op0(DM_LOAD,  0, DM_WORD, 9'h1FF, 0, 0, 32'hA1B2C3D4);
    op0(DM_LOAD,  1, DM_HALF, 9'h1FF, 0, 0, 32'hFFFFA1B2);
    op0(DM_LOAD,  0, DM_WORD, 9'h010, 0, 0, 32'hDEADBEEF);
`endif

    // Sub-word stores; rdata must hold across a store
    op0(DM_STORE, 0, DM_BYTE, 9'h011, 32'h12345655, 0, 0);
    chk("rdata_hold", dif0.rdata, last0);
    op0(DM_LOAD,  0, DM_WORD, 9'h010, 0, 0, 32'hDE55BEEF);
    op0(DM_STORE, 0, DM_HALF, 9'h012, 32'h00007788, 0, 0);
    op0(DM_LOAD,  0, DM_WORD, 9'h010, 0, 0, 32'hDE557788);

    // Wait-state instance
    op3(DM_STORE, 0, DM_WORD, 9'h020, 32'hCAFEF00D, 0);
    op3(DM_LOAD,  0, DM_WORD, 9'h020, 0, 32'hCAFEF00D);

    // Reset in WAIT of a store must abort it
    @(negedge Clk);
    dif3.MEM_load_instr = 1'b1;
    dif3.MEM_Read_Write = DM_STORE;
    dif3.MEM_SE_dm      = 1'b0;
    dif3.MEM_size_dm    = DM_WORD;
    dif3.addr           = 9'h020;
    dif3.wdata          = 32'h12345678;
    repeat (2) @(negedge Clk);
    idle3();
    #2 R3 = 1'b0;
    #1;
    chk("abort_rdata", dif3.rdata, 32'h0);
    chk("abort_valid", {31'b0, dif3.rdata_valid}, 32'h0);
    chk("abort_stall", {31'b0, dif3.mem_stall}, 32'h0);
    chk("abort_fault", {31'b0, dif3.misalign_fault}, 32'h0);
    @(negedge Clk);
    R3 = 1'b1;
    op3(DM_LOAD,  0, DM_WORD, 9'h020, 0, 32'hCAFEF00D);
    op3(DM_LOAD,  0, DM_HALF, 9'h022, 0, 32'h0000F00D);

    repeat (4) @(negedge Clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    chk("ws0_never_stalled", {31'b0, stall0_seen}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
